// File: rtl/alu_disp_pkg.sv
// Shared constants and types for the arithmetic-result to BCD display path.
package alu_disp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_result_bcd_if.sv
// Handshake bundle between the arithmetic unit, the BCD converter and the display driver.
interface alu_result_bcd_if #(
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8:0]            in_result;
  logic [1:0]            in_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  flag;
  logic                  neg;

  modport master (
    output in_valid, in_result, in_op, out_ready,
    input  in_ready, out_valid, bcd, flag, neg
  );

  modport slave (
    input  in_valid, in_result, in_op, out_ready,
    output in_ready, out_valid, bcd, flag, neg
  );
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
  import alu_disp_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= BCD_ADJ_THRESH) ? d + BCD_ADJ_ADD : d;
endmodule

// File: rtl/alu_result_bcd.sv
// Converts the arithmetic unit's result to packed BCD with an iterative double-dabble FSM.
// Optional feature: define SIGNED_SUB_EN to present borrowed differences as sign + magnitude.
module alu_result_bcd
  import alu_disp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_bcd_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [SR_W-1:0]    sreg, sreg_adj, sreg_shl;
  logic [BCD_W-1:0]   bcd_q;
  logic               flag_p, flag_q;
  logic [DATA_W-1:0]  value;
  logic               flag_in;
  logic               accept, last_shift;

`ifdef SIGNED_SUB_EN
  logic               neg_in, neg_p, neg_q;
`endif

  assign accept     = bus.in_valid && (state == IDLE);
  assign last_shift = (state == SHIFT) && (count == CNT_W'(1));

  // in_result[7:4] is only looked at for mul/div, so undriven bits never leak into add/sub.
  always_comb begin
    value   = '0;
    flag_in = 1'b0;
`ifdef SIGNED_SUB_EN
    neg_in  = 1'b0;
`endif
    case (bus.in_op)
      OP_ADD: value = DATA_W'({bus.in_result[8], bus.in_result[3:0]});
      OP_SUB: begin
        flag_in = bus.in_result[8];
`ifdef SIGNED_SUB_EN
        if (bus.in_result[8]) begin
          value  = DATA_W'(5'd16 - {1'b0, bus.in_result[3:0]});
          neg_in = 1'b1;
        end else begin
          value  = DATA_W'(bus.in_result[3:0]);
        end
`else
        value   = DATA_W'(bus.in_result[3:0]);
`endif
      end
      OP_MUL, OP_DIV: begin
        value   = DATA_W'(bus.in_result[7:0]);
        flag_in = bus.in_result[8];
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_add3 u_add3 (
      .d (sreg[DATA_W + 4*i +: 4]),
      .q (sreg_adj[DATA_W + 4*i +: 4])
    );
  end
  assign sreg_adj[DATA_W-1:0] = sreg[DATA_W-1:0];
  assign sreg_shl             = sreg_adj << 1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_shift) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because the visible bcd/flag must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      sreg   <= '0;
      bcd_q  <= '0;
      flag_p <= 1'b0;
      flag_q <= 1'b0;
    end else if (accept) begin
      sreg   <= {{BCD_W{1'b0}}, value};
      count  <= CNT_W'(DATA_W);
      flag_p <= flag_in;
    end else if (state == SHIFT) begin
      sreg  <= sreg_shl;
      count <= count - CNT_W'(1);
      if (last_shift) begin
        bcd_q  <= sreg_shl[SR_W-1 -: BCD_W];
        flag_q <= flag_p;
      end
    end
  end

`ifdef SIGNED_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_p <= 1'b0;
      neg_q <= 1'b0;
    end else if (accept) begin
      neg_p <= neg_in;
    end else if (last_shift) begin
      neg_q <= neg_p;
    end
  end
  assign bus.neg = neg_q;
`else
  assign bus.neg = 1'b0;
`endif

  assign bus.bcd  = bcd_q;
  assign bus.flag = flag_q;

endmodule

// File: tb/tb_alu_result_bcd.sv
// Randomized self-checking bench for alu_result_bcd against a decimal reference model.
module tb_alu_result_bcd;

  localparam int DATA_W = 8;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_result_bcd_if #(.DIGITS(DIGITS)) bus ();

  alu_result_bcd #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal value from the op rules, then digits by division.
  function automatic void model(input logic [8:0] r, input logic [1:0] op,
                                output logic [11:0] b, output logic f, output logic n);
    int v;
    v = 0; f = 1'b0; n = 1'b0;
    case (op)
      2'd0: v = (r[8] ? 16 : 0) + int'(r[3:0]);
      2'd1: begin
        f = r[8];
        v = int'(r[3:0]);
`ifdef SIGNED_SUB_EN
        if (r[8]) begin
          v = 16 - int'(r[3:0]);
          n = 1'b1;
        end
`endif
      end
      default: begin
        v = int'(r[7:0]);
        f = r[8];
      end
    endcase
    b = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic start(input logic [8:0] r, input logic [1:0] op);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) check("ready_timeout", 32'd0, 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_result = r;
    bus.in_op     = op;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_result = 'x;
  endtask

  task automatic wait_out();
    int lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("latency", 32'(lat), 32'(DATA_W));
  endtask

  task automatic check_out(input string tag, input logic [11:0] b, input logic f, input logic n);
    check({tag, "_bcd"},  32'(bus.bcd),  32'(b));
    check({tag, "_flag"}, 32'(bus.flag), 32'(f));
    check({tag, "_neg"},  32'(bus.neg),  32'(n));
  endtask

  task automatic do_txn(input string tag, input logic [8:0] r, input logic [1:0] op, input int stall);
    logic [11:0] b;
    logic f, n;
    logic [8:0] r_drv;
    model(r, op, b, f, n);
    r_drv = r;
    if (op < 2'd2) r_drv[7:4] = 4'bxxxx;
    start(r_drv, op);
    wait_out();
    check_out(tag, b, f, n);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_bcd"},   32'(bus.bcd),       32'(b));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_release"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [11:0] b1, b2;
    logic f1, n1, f2, n2;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_out("rst", 12'h000, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the design's worked examples.
    do_txn("add_9p8", 9'b1_0000_0001, 2'b00, 0);
    do_txn("mul_ff",  9'h1FF,         2'b10, 0);
    do_txn("div_7f",  9'h17F,         2'b11, 1);
    do_txn("sub_3m5", 9'b1_0000_1110, 2'b01, 0);

    // Backpressure: a second request waits until after the output handshake.
    model(9'h0C8, 2'b10, b1, f1, n1);
    model(9'h063, 2'b11, b2, f2, n2);
    start(9'h0C8, 2'b10);
    wait_out();
    check_out("bp1", b1, f1, n1);
    bus.in_valid  = 1'b1;
    bus.in_result = 9'h063;
    bus.in_op     = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_bcd",       32'(bus.bcd),       32'(b1));
      check("bp_flag",      32'(bus.flag),      32'(f1));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_idle_ready", 32'(bus.in_ready),  32'd1);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_accepted", 32'(bus.in_ready), 32'd0);
    wait_out();
    check_out("bp2", b2, f2, n2);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset mid-conversion, after four shifts.
    start(9'h1FF, 2'b10);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    check_out("midrst", 12'h000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_txn("add_7p7", 9'b0_0000_1110, 2'b00, 0);

    // Full sweep of every result value under every op, random output stalls.
    for (int op = 0; op < 4; op++) begin
      for (int r = 0; r < 512; r++) begin
        do_txn("sweep", 9'(r), 2'(op), int'($urandom_range(0, 2)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
